// File: rtl/vram_write_port_pkg.sv
// Shared defaults and helpers for the VRAM write port and its write buffer.
package vram_write_port_pkg;

    // Display geometry and VRAM defaults
    localparam int H_RES_DEF      = 640;
    localparam int V_RES_DEF      = 480;
    localparam int COLOR_W_DEF    = 9;
    localparam int ADDR_W_DEF     = 19;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int SCREEN_PIXELS  = H_RES_DEF * V_RES_DEF;

    localparam logic [COLOR_W_DEF-1:0] CLEAR_COLOR_DEF = 9'b000_000_000;

    // Top-level state machine encoding
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    // Which requester owns the VRAM port on the coming edge
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_SCAN  = 2'd1,
        GNT_FIFO  = 2'd2,
        GNT_CLEAR = 2'd3
    } grant_t;

    // Event counter increment that sticks at 255
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/vram_write_port_sync_fifo.sv
// Small synchronous FIFO buffering linearised pixel writes ahead of VRAM.
// Head entry is presented combinationally on pop_data.
module sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = store[rd_ptr];

    // Storage array: data only, never reset
    always_ff @(posedge clock) begin
        if (do_push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/vram_write_port.sv
// VRAM write port: clears the framebuffer after reset, then accepts a pixel
// stream, bounds-checks and linearises it, buffers it and drains it into a
// single-port VRAM. Display scan reads always win the port.
// ADDR_W must be large enough that 2**ADDR_W >= H_RES*V_RES.
module vram_write_port
    import vram_write_port_pkg::*;
#(
    parameter int                 H_RES       = H_RES_DEF,
    parameter int                 V_RES       = V_RES_DEF,
    parameter int                 COLOR_W     = COLOR_W_DEF,
    parameter int                 ADDR_W      = ADDR_W_DEF,
    parameter int                 FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = COLOR_W'(CLEAR_COLOR_DEF)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [9:0]         wr_x,
    input  logic [8:0]         wr_y,
    input  logic [COLOR_W-1:0] wr_color,
    input  logic               wr_en,
    output logic               wr_ready,
    output logic               clear_done,
    input  logic               scan_req,
    input  logic [ADDR_W-1:0]  scan_addr,
    output logic [COLOR_W-1:0] scan_data,
    output logic               scan_valid,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [COLOR_W-1:0] mem_wdata,
    output logic               mem_we,
    input  logic [COLOR_W-1:0] mem_rdata,
    output logic [7:0]         clip_count,
    output logic [7:0]         drop_count
);

    localparam int                ENTRY_W   = ADDR_W + COLOR_W;
    localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [ADDR_W-1:0] H_RES_A   = ADDR_W'(H_RES);

    // Control state
    logic [0:0]        state;
    logic [ADDR_W-1:0] clear_ctr;
    grant_t            grant;

    // Input stage s1
    logic               s1_valid;
    logic [9:0]         s1_x;
    logic [8:0]         s1_y;
    logic [COLOR_W-1:0] s1_color;
    logic               s1_in_range;
    logic [ADDR_W-1:0]  s1_addr;

    // Scan request stage and read-issued marker
    logic              scan_pend;
    logic [ADDR_W-1:0] scan_addr_q;
    logic              rd_issued;

    // Write buffer interface
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ADDR_W-1:0]  head_addr;
    logic [COLOR_W-1:0] head_color;

    assign s1_in_range = (32'(s1_x) < 32'(H_RES)) && (32'(s1_y) < 32'(V_RES));
    assign s1_addr     = ADDR_W'(s1_y) * H_RES_A + ADDR_W'(s1_x);
    assign fifo_push   = s1_valid && s1_in_range && !fifo_full;
    assign fifo_pop    = (grant == GNT_FIFO);
    assign head_addr   = fifo_head[ENTRY_W-1:COLOR_W];
    assign head_color  = fifo_head[COLOR_W-1:0];

    // One slot is kept free for a pixel that may already sit in s1
    assign wr_ready  = (state == ST_RUN) && (fifo_count <= CNT_W'(FIFO_DEPTH - 2));
    assign scan_data = mem_rdata;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data ({s1_addr, s1_color}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Port arbitration: scan, then buffered writes, then the clear sweep
    always_comb begin
        grant = GNT_NONE;
        if (scan_pend) begin
            grant = GNT_SCAN;
        end else if (!fifo_empty) begin
            grant = GNT_FIFO;
        end else if (state == ST_CLEAR) begin
            grant = GNT_CLEAR;
        end
    end

    // Input stage valid: pixels are only taken once the clear has finished
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= wr_en && (state == ST_RUN);
        end
    end

    // Input stage payload
    always_ff @(posedge clock) begin
        if (wr_en && (state == ST_RUN)) begin
            s1_x     <= wr_x;
            s1_y     <= wr_y;
            s1_color <= wr_color;
        end
    end

    // Scan request registration and read-data valid pipeline
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            scan_pend   <= 1'b0;
            scan_addr_q <= '0;
            rd_issued   <= 1'b0;
            scan_valid  <= 1'b0;
        end else begin
            scan_pend   <= scan_req;
            scan_addr_q <= scan_addr;
            rd_issued   <= (grant == GNT_SCAN);
            scan_valid  <= rd_issued;
        end
    end

    // Registered VRAM port driven by the granted requester
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (grant)
                GNT_SCAN: begin
                    mem_we   <= 1'b0;
                    mem_addr <= scan_addr_q;
                end
                GNT_FIFO: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= head_addr;
                    mem_wdata <= head_color;
                end
                GNT_CLEAR: begin
                    mem_we    <= 1'b1;
                    mem_addr  <= clear_ctr;
                    mem_wdata <= CLEAR_COLOR;
                end
                default: begin
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    // Clear sweep: advance only on granted cycles, enter RUN on the last pixel
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_CLEAR;
            clear_ctr  <= '0;
            clear_done <= 1'b0;
        end else if (grant == GNT_CLEAR) begin
            clear_ctr <= clear_ctr + ADDR_W'(1);
            if (clear_ctr == LAST_ADDR) begin
                state      <= ST_RUN;
                clear_done <= 1'b1;
            end
        end
    end

    // Saturating counters for clipped and overflowed pixels
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            clip_count <= '0;
            drop_count <= '0;
        end else begin
            if (s1_valid && !s1_in_range) begin
                clip_count <= sat_inc8(clip_count);
            end
            if (s1_valid && s1_in_range && fifo_full) begin
                drop_count <= sat_inc8(drop_count);
            end
        end
    end

endmodule

// File: doc/vram_write_port.md
Name: vram_write_port

Overview:
- Receiving end of the pixel write stream (x, y, color, write) that player_drawer and the maze renderer drive.
- Bounds-checks each pixel, linearises it to a VRAM address, buffers it in a small FIFO, and drains it into a single-port VRAM.
- Display scan reads always have priority over buffered writes.
- After reset, clears the whole framebuffer to CLEAR_COLOR, then asserts clear_done; producers use clear_done to gate their start.

Parameters:
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- COLOR_W, 9, pixel color width (RRR GGG BBB)
- ADDR_W, 19, VRAM address width; must satisfy 2^ADDR_W >= H_RES*V_RES
- FIFO_DEPTH, 8, write buffer entries (power of two, >= 4)
- CLEAR_COLOR, 9'b000_000_000, fill value used by the post-reset clear

Ports:
- clock  in  1  system clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- wr_x  in  10  pixel x
- wr_y  in  9  pixel y
- wr_color  in  COLOR_W  pixel color
- wr_en  in  1  write request, sampled each edge
- wr_ready  out  1  write can be accepted without loss
- clear_done  out  1  framebuffer clear finished
- scan_req  in  1  display read request
- scan_addr  in  ADDR_W  display read address
- scan_data  out  COLOR_W  read data
- scan_valid  out  1  scan_data valid
- mem_addr  out  ADDR_W  VRAM address (registered)
- mem_wdata  out  COLOR_W  VRAM write data (registered)
- mem_we  out  1  VRAM write enable (registered)
- mem_rdata  in  COLOR_W  VRAM read data, 1-cycle latency
- clip_count  out  8  out-of-range writes, saturating
- drop_count  out  8  writes lost to a full FIFO, saturating

Behaviour:
- Reset (asynchronous, any time including mid-clear or mid-drain):
  - Outputs go to 0: wr_ready, clear_done, scan_valid, mem_we, mem_addr, mem_wdata, clip_count, drop_count.
  - FIFO and input stage are emptied.
  - State machine goes to CLEAR with the clear counter at 0.
- State machine, two states:
  - CLEAR: each cycle without scan_req, write CLEAR_COLOR to address clear_ctr, then increment clear_ctr. When the write at H_RES*V_RES-1 is issued, move to RUN and set clear_done=1 on the same edge. wr_ready=0 throughout; wr_en is ignored and not counted.
  - RUN: permanent until reset. clear_done stays 1.
- Input stage (RUN only):
  - wr_en=1 sampled at edge k registers {x, y, color} into stage s1.
  - At edge k+1, s1 is pushed into the FIFO with addr = y*H_RES + x. Arithmetic is ADDR_W wide and unsigned.
  - If x >= H_RES or y >= V_RES, the pixel is discarded instead and clip_count increments.
  - If the FIFO is full at push time, the pixel is discarded and drop_count increments.
  - Both counters saturate at 255.
- wr_ready = (state==RUN) && (fifo_count <= FIFO_DEPTH-2). This leaves room for the in-flight s1 entry. Producers that ignore wr_ready lose pixels, visible in drop_count.
- Arbiter, evaluated each edge:
  - scan_req=1: read grant. mem_we<=0, mem_addr<=scan_addr.
  - else FIFO non-empty (RUN): pop head. mem_we<=1, mem_addr/mem_wdata <= head.
  - else CLEAR without scan_req: clear write as described above.
  - else mem_we<=0.
- Scan read timing:
  - scan_req sampled at edge k puts the address on mem at k+1.
  - scan_valid=1 from edge k+2 for one cycle, with scan_data = mem_rdata (combinational pass-through).
  - Back-to-back requests give back-to-back valids.
- Write latency with FIFO empty and no scan_req: wr_en at edge k gives mem_we=1 with the matching address from edge k+2.
- Scan priority is absolute. Writes stall while scan_req is held; no starvation timer.
- Simultaneous push and pop in one cycle: fifo_count unchanged. Pop from an empty FIFO never happens; the same-edge push is not visible until the next cycle.
- Ordering: writes reach VRAM in acceptance order. Two writes to the same pixel resolve last-wins.

Decomposition:
- H_RES, V_RES, COLOR_W and ADDR_W defaults, plus CLEAR_COLOR, go in params.vh beside CELL_SIZE and MAZE_X0. The package also gets a SCREEN_PIXELS = H_RES*V_RES define.
- One sub-module: sync_fifo.
  - Parameters: width = ADDR_W+COLOR_W, depth = FIFO_DEPTH.
  - Ports: push, pop, full, empty, count.
  - Same clock and asynchronous active-low resetn.
  - Arbiter, input stage, clear FSM and counters live in vram_write_port.

Test Plan:
- Bench configuration: H_RES=8, V_RES=4, FIFO_DEPTH=8.
1. Clear: resetn low then high, no scan_req → 32 writes of CLEAR_COLOR to addresses 0..31 on consecutive cycles. clear_done rises on the edge that issues address 31. wr_ready=0 until then.
2. Latency and address: in RUN, wr_en at edge k with x=3, y=2, color=9'h1F8 → mem_we=1, mem_addr=19, mem_wdata=9'h1F8 from edge k+2.
3. Clipping: writes (8,0) and (0,4) → no mem_we; clip_count=2. A following in-range write (7,3) reaches address 31.
4. Priority and overflow:
   - Setup: hold scan_req=1 for 20 cycles while pulsing wr_en on 12 consecutive cycles.
   - Writes: wr_ready falls at count 7; drop_count=4; after scan_req drops, 8 writes drain in order.
   - Scans: scan_valid tracks each request 2 cycles later.
5. Scan during clear: scan_req pulses in CLEAR → clear pauses on those cycles, resumes at the same clear_ctr, and still covers all 32 addresses exactly once.
6. Mid-operation reset: assert resetn while the FIFO holds 5 entries → mem_we=0 immediately, the buffered writes never appear, counters=0, and the clear restarts at address 0.
